// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq
//  Purpose  : Program-counter sequencer. Owns the PC and IR registers and
//             drives the MPC select code. It handles the reset-vector fetch,
//             instruction-word fetches with PC+2 increment and bounded wait,
//             and jump loads from CALC_OUT.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_seq #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        jump_req,
  input  logic [15:0] CALC_OUT,
  input  logic [15:0] MDB,
  input  logic        mem_rdy,
  output logic [15:0] MAB,
  output logic        mem_rd,
  output logic [2:0]  MPC,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic        ir_valid,
  output logic        busy,
  output logic        fault
);

  // Sequencer states
  localparam logic [1:0] S_RST_VEC = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_FETCH   = 2'd2;

  // PC source select codes (4-7 are reserved and never produced)
  localparam logic [2:0] c_mpc_hold = 3'd0;
  localparam logic [2:0] c_mpc_inc  = 3'd1;
  localparam logic [2:0] c_mpc_mdb  = 3'd2;
  localparam logic [2:0] c_mpc_calc = 3'd3;

  // A fetch times out on the cycle the wait count would reach MAX_WAIT,
  // i.e. after exactly MAX_WAIT FETCH cycles without mem_rdy.
  localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [7:0]  r_wait_cnt;
  logic        r_ir_valid;
  logic        r_fault;

  logic [2:0]  w_mpc;
  logic [15:0] w_mab;
  logic        w_mem_rd;
  logic        w_busy;
  logic        w_timeout;

  // Bus strobes and PC-source select decoded from state and mem_rdy; the
  // bus-facing outputs are forced quiet while reset is asserted.
  always_comb begin
    w_mpc    = c_mpc_hold;
    w_mab    = r_pc;
    w_mem_rd = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      S_RST_VEC: begin
        w_mem_rd = 1'b1;
        w_mab    = RESET_VECTOR;
        w_busy   = 1'b1;
        if (mem_rdy) w_mpc = c_mpc_mdb;
      end
      S_IDLE: begin
        if (jump_req) w_mpc = c_mpc_calc;
      end
      S_FETCH: begin
        w_mem_rd = 1'b1;
        w_busy   = 1'b1;
        if (mem_rdy) w_mpc = c_mpc_inc;
      end
      default: begin
        w_mpc = c_mpc_hold;
      end
    endcase
    if (!rst_n) begin
      w_mpc    = c_mpc_hold;
      w_mab    = 16'h0000;
      w_mem_rd = 1'b0;
    end
  end

  assign w_timeout = (r_state == S_FETCH) && !mem_rdy && (r_wait_cnt == c_wait_last);

  // PC register: loaded from the source the MPC code selects; bit0 kept clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= 16'h0000;
    end else begin
      case (w_mpc)
        c_mpc_inc:  r_pc <= r_pc + 16'd2;
        c_mpc_mdb:  r_pc <= MDB & 16'hFFFE;
        c_mpc_calc: r_pc <= CALC_OUT & 16'hFFFE;
        default:    r_pc <= r_pc;
      endcase
    end
  end

  // State machine, wait counter, IR capture and the one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RST_VEC;
      r_ir       <= 16'h0000;
      r_wait_cnt <= 8'd0;
      r_ir_valid <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        S_RST_VEC: begin
          if (mem_rdy) r_state <= S_IDLE;
        end
        S_IDLE: begin
          // A jump completes in IDLE and takes priority over a fetch request
          if (!jump_req && fetch_req) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
          end
        end
        S_FETCH: begin
          if (mem_rdy) begin
            r_ir       <= MDB;
            r_ir_valid <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_RST_VEC;
        end
      endcase
    end
  end

  assign MAB      = w_mab;
  assign mem_rd   = w_mem_rd;
  assign MPC      = w_mpc;
  assign busy     = w_busy;
  assign PC       = r_pc;
  assign IR       = r_ir;
  assign ir_valid = r_ir_valid;
  assign fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_seq
//  Purpose  : Directed self-checking bench for pc_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_seq;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        jump_req;
  logic [15:0] CALC_OUT;
  logic [15:0] MDB;
  logic        mem_rdy;
  logic [15:0] MAB;
  logic        mem_rd;
  logic [2:0]  MPC;
  logic [15:0] PC;
  logic [15:0] IR;
  logic        ir_valid;
  logic        busy;
  logic        fault;

  int n_vec;
  int n_err;

  pc_seq #(.RESET_VECTOR(16'hFFFE), .MAX_WAIT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_req(fetch_req),
    .jump_req (jump_req),
    .CALC_OUT (CALC_OUT),
    .MDB      (MDB),
    .mem_rdy  (mem_rdy),
    .MAB      (MAB),
    .mem_rd   (mem_rd),
    .MPC      (MPC),
    .PC       (PC),
    .IR       (IR),
    .ir_valid (ir_valid),
    .busy     (busy),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b0; jump_req = 1'b0;
    CALC_OUT = 16'h0000; MDB = 16'h0000; mem_rdy = 1'b0;
    repeat (3) tick();
    #1;
    n_vec++; if (PC !== 16'h0000) begin n_err++; $display("FAIL rst_pc: got %h exp %h", PC, 16'h0000); end
    n_vec++; if (IR !== 16'h0000) begin n_err++; $display("FAIL rst_ir: got %h exp %h", IR, 16'h0000); end
    n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd: got %b exp 0", mem_rd); end
    n_vec++; if (MAB !== 16'h0000) begin n_err++; $display("FAIL rst_mab: got %h exp 0000", MAB); end
    n_vec++; if (MPC !== 3'd0) begin n_err++; $display("FAIL rst_mpc: got %0d exp 0", MPC); end
    n_vec++; if (ir_valid !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got %b%b exp 00", ir_valid, fault); end
    // first post-reset cycle: vector fetch, no data yet
    rst_n = 1'b1;
    #1;
    n_vec++; if (MAB !== 16'hFFFE) begin n_err++; $display("FAIL vec_mab: got %h exp FFFE", MAB); end
    n_vec++; if (mem_rd !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL vec_rd_busy: got %b%b exp 11", mem_rd, busy); end
    n_vec++; if (MPC !== 3'd0) begin n_err++; $display("FAIL vec_wait_mpc: got %0d exp 0", MPC); end
    tick();
    // second post-reset cycle: vector data arrives
    MDB = 16'hC001; mem_rdy = 1'b1;
    #1;
    n_vec++; if (MPC !== 3'd2) begin n_err++; $display("FAIL vec_mpc: got %0d exp 2", MPC); end
    n_vec++; if (MAB !== 16'hFFFE || mem_rd !== 1'b1) begin n_err++; $display("FAIL vec_mab2: got %h/%b exp FFFE/1", MAB, mem_rd); end
    tick();
    mem_rdy = 1'b0;
    #1;
    n_vec++; if (PC !== 16'hC000) begin n_err++; $display("FAIL vec_pc: got %h exp C000", PC); end
    n_vec++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL vec_idle: got busy=%b rd=%b exp 0/0", busy, mem_rd); end
    n_vec++; if (MAB !== 16'hC000) begin n_err++; $display("FAIL idle_mab: got %h exp C000", MAB); end
  endtask

  // PC=C000; data arrives in the second FETCH cycle
  task automatic test_fetch();
    fetch_req = 1'b1;
    #1;
    n_vec++; if (MPC !== 3'd0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL fetch_req_cycle: got mpc=%0d rd=%b exp 0/0", MPC, mem_rd); end
    tick();
    fetch_req = 1'b0;
    #1;
    n_vec++; if (MAB !== 16'hC000 || mem_rd !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL fetch_w1: got %h/%b/%b exp C000/1/1", MAB, mem_rd, busy); end
    n_vec++; if (MPC !== 3'd0) begin n_err++; $display("FAIL fetch_w1_mpc: got %0d exp 0", MPC); end
    tick();
    MDB = 16'h4031; mem_rdy = 1'b1;
    #1;
    n_vec++; if (MAB !== 16'hC000 || MPC !== 3'd1) begin n_err++; $display("FAIL fetch_done: got mab=%h mpc=%0d exp C000/1", MAB, MPC); end
    tick();
    mem_rdy = 1'b0;
    #1;
    n_vec++; if (IR !== 16'h4031) begin n_err++; $display("FAIL fetch_ir: got %h exp 4031", IR); end
    n_vec++; if (PC !== 16'hC002) begin n_err++; $display("FAIL fetch_pc: got %h exp C002", PC); end
    n_vec++; if (ir_valid !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL fetch_valid: got v=%b busy=%b exp 1/0", ir_valid, busy); end
    tick();
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fetch_valid_len: got %b exp 0", ir_valid); end
  endtask

  // mem_rdy while IDLE has no effect
  task automatic test_idle_rdy();
    MDB = 16'h7777; mem_rdy = 1'b1;
    #1;
    n_vec++; if (MPC !== 3'd0) begin n_err++; $display("FAIL idle_rdy_mpc: got %0d exp 0", MPC); end
    tick();
    mem_rdy = 1'b0;
    n_vec++; if (PC !== 16'hC002 || IR !== 16'h4031 || ir_valid !== 1'b0) begin n_err++; $display("FAIL idle_rdy: got pc=%h ir=%h v=%b exp C002/4031/0", PC, IR, ir_valid); end
  endtask

  // Jump takes priority over a simultaneous fetch
  task automatic test_jump();
    fetch_req = 1'b1; jump_req = 1'b1; CALC_OUT = 16'hA001;
    #1;
    n_vec++; if (MPC !== 3'd3) begin n_err++; $display("FAIL jump_mpc: got %0d exp 3", MPC); end
    n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL jump_rd: got %b exp 0", mem_rd); end
    tick();
    fetch_req = 1'b0; jump_req = 1'b0;
    #1;
    n_vec++; if (PC !== 16'hA000) begin n_err++; $display("FAIL jump_pc: got %h exp A000", PC); end
    n_vec++; if (busy !== 1'b0 || mem_rd !== 1'b0 || MAB !== 16'hA000) begin n_err++; $display("FAIL jump_idle: got busy=%b rd=%b mab=%h exp 0/0/A000", busy, mem_rd, MAB); end
  endtask

  // PC wraps from FFFE to 0000
  task automatic test_wrap();
    jump_req = 1'b1; CALC_OUT = 16'hFFFF;
    tick();
    jump_req = 1'b0;
    n_vec++; if (PC !== 16'hFFFE) begin n_err++; $display("FAIL wrap_jump_pc: got %h exp FFFE", PC); end
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; MDB = 16'h1234; mem_rdy = 1'b1;
    #1;
    n_vec++; if (MAB !== 16'hFFFE || MPC !== 3'd1) begin n_err++; $display("FAIL wrap_fetch: got mab=%h mpc=%0d exp FFFE/1", MAB, MPC); end
    tick();
    mem_rdy = 1'b0;
    n_vec++; if (IR !== 16'h1234 || PC !== 16'h0000) begin n_err++; $display("FAIL wrap_result: got ir=%h pc=%h exp 1234/0000", IR, PC); end
  endtask

  // 15 FETCH cycles without data -> fault, state unchanged, retry succeeds
  task automatic test_timeout();
    int bad_wait;
    bad_wait = 0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (busy !== 1'b1 || fault !== 1'b0 || MPC !== 3'd0) bad_wait++;
      tick();
    end
    n_vec++; if (bad_wait != 0) begin n_err++; $display("FAIL to_wait: bad cycles got %0d exp 0", bad_wait); end
    n_vec++; if (fault !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL to_fault: got fault=%b busy=%b exp 1/0", fault, busy); end
    n_vec++; if (PC !== 16'h0000 || IR !== 16'h1234 || ir_valid !== 1'b0) begin n_err++; $display("FAIL to_state: got pc=%h ir=%h v=%b exp 0000/1234/0", PC, IR, ir_valid); end
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL to_fault_len: got %b exp 0", fault); end
    MDB = 16'h5678; mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    n_vec++; if (IR !== 16'h5678 || PC !== 16'h0002 || ir_valid !== 1'b1 || fault !== 1'b0) begin n_err++; $display("FAIL to_retry: got ir=%h pc=%h v=%b f=%b exp 5678/0002/1/0", IR, PC, ir_valid, fault); end
  endtask

  // Data on the 15th wait cycle wins over the timeout
  task automatic test_timeout_edge();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    repeat (14) tick();
    MDB = 16'h9ABC; mem_rdy = 1'b1;
    #1;
    n_vec++; if (MPC !== 3'd1) begin n_err++; $display("FAIL edge_mpc: got %0d exp 1", MPC); end
    tick();
    mem_rdy = 1'b0;
    n_vec++; if (fault !== 1'b0 || ir_valid !== 1'b1 || IR !== 16'h9ABC || PC !== 16'h0004) begin n_err++; $display("FAIL edge_result: got f=%b v=%b ir=%h pc=%h exp 0/1/9ABC/0004", fault, ir_valid, IR, PC); end
  endtask

  // Asynchronous reset in the middle of a FETCH wait
  task automatic test_async_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (PC !== 16'h0000 || IR !== 16'h0000) begin n_err++; $display("FAIL ares_regs: got pc=%h ir=%h exp 0000/0000", PC, IR); end
    n_vec++; if (mem_rd !== 1'b0 || MAB !== 16'h0000 || MPC !== 3'd0) begin n_err++; $display("FAIL ares_bus: got rd=%b mab=%h mpc=%0d exp 0/0000/0", mem_rd, MAB, MPC); end
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    n_vec++; if (MAB !== 16'hFFFE || mem_rd !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL ares_vec: got mab=%h rd=%b busy=%b exp FFFE/1/1", MAB, mem_rd, busy); end
    tick();
    MDB = 16'hC001; mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    n_vec++; if (PC !== 16'hC000 || busy !== 1'b0) begin n_err++; $display("FAIL ares_refetch: got pc=%h busy=%b exp C000/0", PC, busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fetch();
    test_idle_rdy();
    test_jump();
    test_wrap();
    test_timeout();
    test_timeout_edge();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Program-counter sequencer: the control-side counterpart of the PC input mux. It owns the PC register and drives the 3-bit MPC select code. It fetches the reset vector, performs instruction-word fetches with PC+2 increment, and loads jump targets from CALC_OUT. It sits between the core control unit (fetch_req/jump_req) and the memory bus (MAB/MDB/mem_rdy).

Parameters:
RESET_VECTOR, 16'hFFFE, address of the reset vector word
MAX_WAIT, 15, maximum wait cycles for mem_rdy during FETCH before aborting (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_req  input  1  request an instruction-word fetch at the current PC (sampled in IDLE only)
jump_req  input  1  load PC from CALC_OUT (sampled in IDLE only)
CALC_OUT  input  16  jump target from the address calculator
MDB  input  16  memory data bus
mem_rdy  input  1  memory read data valid on MDB this cycle
MAB  output  16  memory address bus
mem_rd  output  1  memory read strobe
MPC  output  3  PC source select: 0 hold, 1 PC+2, 2 MDB, 3 CALC_OUT, 4-7 reserved (never driven)
PC  output  16  current program counter (registered)
IR  output  16  last fetched instruction word (registered)
ir_valid  output  1  one-cycle pulse after IR capture
busy  output  1  high in RST_VEC and FETCH
fault  output  1  one-cycle pulse on fetch timeout

Behaviour:
- Reset (rst_n low, asynchronous): state=RST_VEC, PC=0, IR=0, wait counter=0, ir_valid=0, fault=0. While rst_n is low, mem_rd=0, MAB=0, MPC=0.
- MPC, MAB, mem_rd and busy are combinational decodes of state and mem_rdy. PC, IR, ir_valid and fault are registered.
- RST_VEC:
  - mem_rd=1, MAB=RESET_VECTOR, busy=1. No timeout; waits indefinitely.
  - On mem_rdy: MPC=2, PC<=MDB & 16'hFFFE (bit0 forced 0), next state=IDLE.
- IDLE:
  - busy=0, mem_rd=0, MAB=PC, MPC=0 unless a jump is taken.
  - jump_req=1 (priority over fetch_req): MPC=3, PC<=CALC_OUT & 16'hFFFE, stay IDLE, no memory access.
  - fetch_req=1 alone: next state=FETCH, wait counter<=0.
- FETCH:
  - mem_rd=1, MAB=PC, busy=1. fetch_req and jump_req are ignored.
  - On mem_rdy: IR<=MDB, PC<=PC+2 modulo 2^16 (16'hFFFE -> 16'h0000), MPC=1, ir_valid<=1 for the next cycle, next state=IDLE.
  - Without mem_rdy: counter increments. When counter reaches MAX_WAIT: fault<=1 for the next cycle, PC and IR unchanged, MPC=0, next state=IDLE.
  - mem_rdy in the same cycle the counter hits MAX_WAIT: the data wins, normal completion, no fault.
- Latency: fetch_req in IDLE at cycle N -> FETCH at N+1. With mem_rdy at N+k, ir_valid is high at N+k+1, already in IDLE. Back-to-back fetches are possible by asserting fetch_req in that IDLE cycle.
- mem_rdy outside RST_VEC/FETCH is ignored.
- rst_n asserted mid-operation aborts immediately: state returns to RST_VEC and the vector is re-fetched after release.
- PC bit0 is always 0.

Test Plan:
1. Hold rst_n low 3 cycles, release. MDB=16'hC001 with mem_rdy in the 2nd post-reset cycle -> MAB=16'hFFFE and mem_rd=1 until mem_rdy; MPC=2 in that cycle; PC=16'hC000 next; busy=0.
2. PC=16'hC000, pulse fetch_req; assert mem_rdy 2 cycles into FETCH with MDB=16'h4031 -> MAB=16'hC000 throughout FETCH; MPC=1 in the completion cycle; IR=16'h4031; PC=16'hC002; ir_valid high exactly 1 cycle.
3. In IDLE, assert fetch_req and jump_req together with CALC_OUT=16'hA001 -> MPC=3 that cycle; PC=16'hA000; mem_rd stays 0; state stays IDLE.
4. PC=16'hFFFE, fetch with MDB=16'h1234 -> IR=16'h1234, PC=16'h0000.
5. MAX_WAIT=15, fetch with mem_rdy never asserted -> fault pulses 1 cycle after 15 wait cycles; PC and IR unchanged; busy=0; a subsequent fetch with mem_rdy completes normally.
6. Drop rst_n during FETCH wait -> PC=0, IR=0, mem_rd=0 immediately, without waiting for a clock edge; after release the vector fetch at 16'hFFFE repeats.
